// File: rtl/systolic_pkg.sv
// Shared types, widths and fixed-point helpers for the systolic matrix-vector engine.
// SYSTOLIC_SAT_EN selects clamping narrowing/adds; otherwise results wrap. No storage, no latency.
package systolic_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;

    typedef enum logic [1:0] {
        LOAD,
        FULL,
        DRAIN
    } wstate_e;

    // Bring a wide signed value into the DATA_W range, returned sign-extended.
    function automatic logic signed [63:0] fx_narrow(input logic signed [63:0] v, input int dw);
`ifdef SYSTOLIC_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - dw)) >>> (64 - dw);
`endif
    endfunction

    function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int fw, input int dw);
        return fx_narrow((a * b) >>> fw, dw);
    endfunction

    function automatic logic signed [63:0] fx_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int dw);
        return fx_narrow(a + b, dw);
    endfunction

endpackage

// File: rtl/sa_cell.sv
// Weight-stationary PE: forwards x right, adds x*w to the psum from above; one-cycle latency.
// No backpressure: advances every cycle; the active weight loads only on w_load_i.
module sa_cell
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_load_i,
    input  logic signed [DATA_W-1:0] w_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] psum_i,
    output logic signed [DATA_W-1:0] x_o,
    output logic signed [DATA_W-1:0] psum_o
);

    logic signed [DATA_W-1:0] w_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] psum_q;
    logic signed [DATA_W-1:0] psum_d;

    assign psum_d = DATA_W'(fx_add(64'(psum_i),
                                   fx_mul(64'(x_i), 64'(w_q), FRAC_W, DATA_W),
                                   DATA_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q    <= '0;
            x_q    <= '0;
            psum_q <= '0;
        end else begin
            x_q    <= x_i;
            psum_q <= psum_d;
            if (w_load_i) w_q <= w_i;
        end
    end

    assign x_o    = x_q;
    assign psum_o = psum_q;

endmodule

// File: rtl/systolic_array.sv
// ROWSxCOLS weight-stationary matrix-vector engine with double-buffered weights; y follows x by ROWS+COLS cycles.
// x stalls only while a bank swap drains the pipe; weight rows stall once the shadow bank is full; y has no backpressure.
module systolic_array
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid_in,
    output logic                   w_ready_out,
    input  logic [COLS*DATA_W-1:0] w_data_in,
    input  logic                   switch_in,
    input  logic                   x_valid_in,
    output logic                   x_ready_out,
    input  logic [ROWS*DATA_W-1:0] x_data_in,
    output logic                   y_valid_out,
    output logic [COLS*DATA_W-1:0] y_data_out,
    output logic                   shadow_full_out,
    output logic                   busy_out
);

    localparam int LAT  = ROWS + COLS;
    localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IF_W = $clog2(LAT + 1);

    wstate_e                  state_q, state_d;
    logic [RC_W-1:0]          row_cnt_q, row_cnt_d;
    logic [IF_W-1:0]          inflight_q, inflight_d;
    logic [LAT-1:0]           vld_q;
    logic                     y_valid_q;
    logic [COLS*DATA_W-1:0]   y_data_q, y_data_d;
    logic                     x_acc, w_acc, swap, res_out;

    logic signed [DATA_W-1:0] shadow_q [ROWS][COLS];
    logic signed [DATA_W-1:0] xh       [ROWS][COLS+1];
    logic signed [DATA_W-1:0] ps       [ROWS+1][COLS];
    logic signed [DATA_W-1:0] col_y    [COLS];

    assign x_acc    = x_valid_in & x_ready_out;
    assign w_acc    = w_valid_in & w_ready_out;
    assign res_out  = vld_q[LAT-1];
    assign busy_out = (inflight_q != '0);

    always_comb begin
        state_d         = state_q;
        row_cnt_d       = row_cnt_q;
        w_ready_out     = 1'b0;
        x_ready_out     = 1'b0;
        shadow_full_out = 1'b0;
        swap            = 1'b0;
        case (state_q)
            LOAD: begin
                w_ready_out = 1'b1;
                x_ready_out = 1'b1;
                if (w_valid_in) begin
                    row_cnt_d = row_cnt_q + RC_W'(1);
                    if (row_cnt_q == RC_W'(ROWS - 1)) state_d = FULL;
                end
            end
            FULL: begin
                x_ready_out     = 1'b1;
                shadow_full_out = 1'b1;
                if (switch_in) state_d = DRAIN;
            end
            DRAIN: begin
                // Inputs are held off here, so inflight can only fall.
                if (inflight_q == '0) begin
                    swap      = 1'b1;
                    row_cnt_d = '0;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (x_acc && !res_out && inflight_q != IF_W'(LAT))
            inflight_d = inflight_q + IF_W'(1);
        else if (res_out && !x_acc && inflight_q != '0)
            inflight_d = inflight_q - IF_W'(1);
    end

    always_comb begin
        y_data_d = '0;
        for (int c = 0; c < COLS; c++) y_data_d[c*DATA_W +: DATA_W] = col_y[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            row_cnt_q  <= '0;
            inflight_q <= '0;
            vld_q      <= '0;
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            inflight_q <= inflight_d;
            vld_q      <= {vld_q[LAT-2:0], x_acc};
            y_valid_q  <= res_out;
            y_data_q   <= y_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) shadow_q[r][c] <= '0;
        end else if (w_acc) begin
            for (int c = 0; c < COLS; c++)
                shadow_q[row_cnt_q][c] <= w_data_in[c*DATA_W +: DATA_W];
        end
    end

    // Row r sees its lane r+1 edges after acceptance, so cell (r,c) fires at t+1+r+c.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic signed [DATA_W-1:0] sk_q [r+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= r; k++) sk_q[k] <= '0;
            end else begin
                sk_q[0] <= x_acc ? x_data_in[r*DATA_W +: DATA_W] : '0;
                for (int k = 1; k <= r; k++) sk_q[k] <= sk_q[k-1];
            end
        end
        assign xh[r][0] = sk_q[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_top
        assign ps[0][c] = '0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sa_cell #(
                .DATA_W (DATA_W),
                .FRAC_W (FRAC_W)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .w_load_i (swap),
                .w_i      (shadow_q[r][c]),
                .x_i      (xh[r][c]),
                .psum_i   (ps[r][c]),
                .x_o      (xh[r][c+1]),
                .psum_o   (ps[r+1][c])
            );
        end
    end

    // Column c finishes c cycles early; pad so all lanes align with the last column.
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign col_y[c] = ps[ROWS][c];
        end else begin : g_delay
            logic signed [DATA_W-1:0] dk_q [D];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) dk_q[k] <= '0;
                end else begin
                    dk_q[0] <= ps[ROWS][c];
                    for (int k = 1; k < D; k++) dk_q[k] <= dk_q[k-1];
                end
            end
            assign col_y[c] = dk_q[D-1];
        end
    end

    assign y_valid_out = y_valid_q;
    assign y_data_out  = y_data_q;

endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array: table vectors, directed swap/reset sequences and random streams against a matrix model.
module tb_systolic_array;

    localparam int R   = 4;
    localparam int C   = 4;
    localparam int LAT = R + C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_valid_in = 1'b0, w_ready_out;
    logic [63:0] w_data_in = '0;
    logic        switch_in = 1'b0;
    logic        x_valid_in = 1'b0, x_ready_out;
    logic [63:0] x_data_in = '0;
    logic        y_valid_out;
    logic [63:0] y_data_out;
    logic        shadow_full_out, busy_out;

    always #5 clk = ~clk;

    systolic_array #(.ROWS(R), .COLS(C), .DATA_W(16), .FRAC_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .w_valid_in      (w_valid_in),
        .w_ready_out     (w_ready_out),
        .w_data_in       (w_data_in),
        .switch_in       (switch_in),
        .x_valid_in      (x_valid_in),
        .x_ready_out     (x_ready_out),
        .x_data_in       (x_data_in),
        .y_valid_out     (y_valid_out),
        .y_data_out      (y_data_out),
        .shadow_full_out (shadow_full_out),
        .busy_out        (busy_out)
    );

    typedef struct { logic [63:0] y; int due; } exp_t;
    typedef struct { logic [63:0] x; logic [63:0] y; } vec_t;

    int   tests = 0, fails = 0, cyc = 0, seen = 0;
    exp_t q[$];
    int   vcyc[$];
    int   mw_act [R][C];
    int   mw_sh  [R][C];
    int   rows = 0;
    bit   pending = 0;
    logic [63:0] bank [R];
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint narrow(input longint v);
`ifdef SYSTOLIC_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        longint m = v & 65535;
        if (m > 32767) m -= 65536;
        return m;
`endif
    endfunction

    // y[c] = sum over r of x[r]*W[r][c], narrowed per product and per running sum from row 0 down.
    function automatic logic [63:0] model_y(input logic [63:0] x);
        logic [63:0]        y;
        logic signed [15:0] xs;
        longint             acc;
        y = '0;
        for (int c = 0; c < C; c++) begin
            acc = 0;
            for (int r = 0; r < R; r++) begin
                xs  = x[r*16 +: 16];
                acc = narrow(acc + narrow((longint'(xs) * longint'(mw_act[r][c])) >>> 8));
            end
            y[c*16 +: 16] = acc[15:0];
        end
        return y;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit                 xacc, wacc, full_before;
        logic signed [15:0] wl;
        if (rst) begin
            q.delete();
            pending = 0;
            rows    = 0;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    mw_act[r][c] = 0;
                    mw_sh[r][c]  = 0;
                end
        end else begin
            cyc++;
            full_before = (rows == R) && !pending;
            xacc = x_valid_in && x_ready_out;
            wacc = w_valid_in && w_ready_out;
            // Any handshake after an accepted switch proves the swap already happened.
            if (pending && (xacc || wacc)) begin
                mw_act  = mw_sh;
                pending = 0;
            end
            if (xacc) q.push_back('{model_y(x_data_in), cyc + LAT});
            if (wacc && rows < R) begin
                for (int c = 0; c < C; c++) begin
                    wl = w_data_in[c*16 +: 16];
                    mw_sh[rows][c] = wl;
                end
                rows++;
            end
            if (full_before && switch_in) begin
                pending = 1;
                rows    = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (y_valid_out) begin
                vcyc.push_back(cyc);
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL y_unexpected: got valid %h, expected no result (cycle %0d)", y_data_out, cyc);
                end else begin
                    e = q.pop_front();
                    chk("y_data", y_data_out, e.y);
                    chk("y_latency", 64'(cyc), 64'(e.due));
                    seen++;
                end
            end
            chk("busy", 64'(busy_out), 64'(q.size() != 0));
            chk("shadow_full", 64'(shadow_full_out), 64'(rows == R));
            if (!pending) begin
                chk("x_ready", 64'(x_ready_out), 64'd1);
                chk("w_ready", 64'(w_ready_out), 64'(rows < R));
            end else if (q.size() != 0) begin
                chk("x_ready_drain", 64'(x_ready_out), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_x(input logic [63:0] v);
        bit acc = 0;
        int n   = 0;
        x_valid_in = 1'b1;
        x_data_in  = v;
        while (!acc && n < 60) begin
            acc = x_ready_out;
            tick();
            n++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL x_accept_timeout: got no accept in %0d cycles, expected accept", n);
        end
    endtask

    task automatic load_bank();
        for (int r = 0; r < R; r++) begin
            bit acc = 0;
            int n   = 0;
            w_valid_in = 1'b1;
            w_data_in  = bank[r];
            while (!acc && n < 60) begin
                acc = w_ready_out;
                tick();
                n++;
            end
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL w_accept_timeout: got no accept on row %0d, expected accept", r);
            end
        end
        w_valid_in = 1'b0;
    endtask

    task automatic do_switch();
        switch_in = 1'b1;
        tick();
        switch_in = 1'b0;
    endtask

    task automatic wait_y(output int lat, output logic [63:0] d);
        int n = 0;
        while (!y_valid_out && n < 40) begin
            tick();
            n++;
        end
        lat = n;
        d   = y_data_out;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    function automatic void set_bank_const(input logic [15:0] v);
        for (int r = 0; r < R; r++) bank[r] = {v, v, v, v};
    endfunction

    function automatic void set_bank_identity();
        for (int r = 0; r < R; r++) bank[r] = 64'h0100 << (16 * r);
    endfunction

    initial begin
        int          lat;
        int          s0;
        logic [63:0] d;
        logic [63:0] v;

        // Identity weights reproduce x exactly in Q8.8.
        tbl[0] = '{64'h0400_0300_0200_0100, 64'h0400_0300_0200_0100};
        tbl[1] = '{64'h7FFF_8000_0080_FF00, 64'h7FFF_8000_0080_FF00};
        tbl[2] = '{64'h0001_FFFF_1234_ABCD, 64'h0001_FFFF_1234_ABCD};
        tbl[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

        repeat (3) tick();
        chk("rst_y_valid", 64'(y_valid_out), 64'd0);
        chk("rst_y_data", y_data_out, 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_shadow_full", 64'(shadow_full_out), 64'd0);
        chk("rst_w_ready", 64'(w_ready_out), 64'd1);
        chk("rst_x_ready", 64'(x_ready_out), 64'd1);
        rst = 1'b0;
        tick();

        send_x(64'h1111_2222_3333_4444);
        x_valid_in = 1'b0;
        wait_y(lat, d);
        chk("pre_switch_zero", d, 64'd0);

        set_bank_identity();
        load_bank();
        do_switch();
        for (int i = 0; i < 4; i++) begin
            send_x(tbl[i].x);
            x_valid_in = 1'b0;
            wait_y(lat, d);
            chk("tbl_latency", 64'(lat), 64'(LAT));
            chk("tbl_y", d, tbl[i].y);
            tick();
            chk("tbl_one_cycle", 64'(y_valid_out), 64'd0);
        end
        wait_quiet();

        set_bank_const(16'h0100);
        load_bank();
        do_switch();
        vcyc.delete();
        for (int i = 0; i < 10; i++) send_x({$urandom(), $urandom()});
        x_valid_in = 1'b0;
        wait_quiet();
        chk("stream_count", 64'(vcyc.size()), 64'd10);
        if (vcyc.size() == 10) chk("stream_contiguous", 64'(vcyc[9] - vcyc[0]), 64'd9);

        for (int r = 0; r < R; r++) bank[r] = {$urandom(), $urandom()};
        load_bank();
        s0 = seen;
        send_x({$urandom(), $urandom()});
        send_x({$urandom(), $urandom()});
        switch_in = 1'b1;
        send_x({$urandom(), $urandom()});
        switch_in = 1'b0;
        send_x({$urandom(), $urandom()});
        x_valid_in = 1'b0;
        chk("drain_old_first", 64'(seen - s0), 64'd3);
        wait_quiet();

        set_bank_const(16'h7F00);
        load_bank();
        do_switch();
        send_x(64'h7F00_7F00_7F00_7F00);
        x_valid_in = 1'b0;
        wait_y(lat, d);
`ifdef SYSTOLIC_SAT_EN
        chk("overflow", d, 64'h7FFF_7FFF_7FFF_7FFF);
`else
        chk("overflow", d, 64'h0400_0400_0400_0400);
`endif
        wait_quiet();

        send_x({$urandom(), $urandom()});
        send_x({$urandom(), $urandom()});
        x_valid_in = 1'b0;
        for (int r = 0; r < R; r++) bank[r] = {$urandom(), $urandom()};
        w_valid_in = 1'b1;
        w_data_in  = bank[0];
        tick();
        w_data_in  = bank[1];
        tick();
        w_valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_w_ready", 64'(w_ready_out), 64'd1);
        chk("midrst_shadow_full", 64'(shadow_full_out), 64'd0);
        chk("midrst_y_valid", 64'(y_valid_out), 64'd0);
        chk("midrst_x_ready", 64'(x_ready_out), 64'd1);
        chk("midrst_busy", 64'(busy_out), 64'd0);
        tick();
        rst = 1'b0;
        repeat (12) tick();

        set_bank_identity();
        switch_in = 1'b1;
        load_bank();
        switch_in = 1'b0;
        chk("held_switch_full", 64'(shadow_full_out), 64'd1);
        v = 64'h0040_FFC0_0300_0100;
        send_x(v);
        x_valid_in = 1'b0;
        wait_y(lat, d);
        chk("held_switch_no_swap", d, 64'd0);
        wait_quiet();
        do_switch();
        send_x(v);
        x_valid_in = 1'b0;
        wait_y(lat, d);
        chk("swap_in_full", d, v);
        wait_quiet();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns, expected summary");
        $fatal(1);
    end

endmodule

// File: doc/systolic_array.md
# systolic_array

Parametrised weight-stationary ROWS×COLS systolic matrix-vector engine, the generalised successor of the fixed 2×2 array. It accepts one unskewed input vector per cycle and skews it across rows internally. It accumulates partial sums down each column and deskews the column results into one output vector. Weights are double-buffered: a shadow bank is loaded row by row while the active bank computes, and a switch request swaps the banks once the pipeline has drained.

## Interface
Parameters:
- ROWS, 4: array rows, equal to input vector length; ≥1
- COLS, 4: array columns, equal to output vector length; ≥1
- DATA_W, 16: signed fixed-point word width
- FRAC_W, 8: fractional bits (default Q8.8)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- w_valid_in  in  1  weight row present
- w_ready_out  out  1  shadow bank accepting rows
- w_data_in  in  COLS*DATA_W  weight row; lane c = W[row][c]
- switch_in  in  1  request shadow→active swap (level sampled per cycle)
- x_valid_in  in  1  input vector present
- x_ready_out  out  1  input accepted this cycle when high
- x_data_in  in  ROWS*DATA_W  input vector; lane r = x[r]
- y_valid_out  out  1  result vector valid (no backpressure)
- y_data_out  out  COLS*DATA_W  lane c = Σr x[r]·W[r][c]
- shadow_full_out  out  1  all ROWS shadow rows loaded
- busy_out  out  1  one or more vectors in flight

## Operation
- Weight FSM states:
  - LOAD: w_ready_out=1; each w_valid_in&w_ready_out writes the shadow row at row_cnt, then row_cnt++. On the row_cnt=ROWS-1 write, go to FULL.
  - FULL: w_ready_out=0, shadow_full_out=1. switch_in=1 → DRAIN.
  - DRAIN: x_ready_out=0. When inflight=0 → active←shadow, row_cnt←0, go to LOAD. Shadow contents are retained but logically empty.
- x_ready_out=1 in LOAD and FULL.
- Inflight counter increments on each accepted vector and decrements on each y_valid_out. It saturates at most at ROWS+COLS.
- Handshake rules:
  - switch_in in LOAD is ignored and not remembered.
  - switch_in in the same cycle as the final row write is ignored.
  - An x accept in the same cycle as switch acceptance counts in flight before DRAIN.
- Each cell (sub-module) holds one active weight. It forwards x right and adds x·w to the psum from above, with zero psum entering row 0.
- Arithmetic:
  - Product is full 2·DATA_W signed, arithmetic-shifted right by FRAC_W, then truncated to DATA_W.
  - Adds wrap modulo 2^DATA_W.
- The active bank is zero after reset, so output is all zeros until the first switch.

## Timing
- Latency: a vector accepted at edge t produces y_valid_out high for exactly one cycle after edge t+ROWS+COLS (8 at defaults).
- Throughput: one vector per cycle, with back-to-back results in acceptance order.
- Internal skew: row r delayed r cycles. Deskew: column c delayed COLS-1-c cycles.
- Swap occurs at the first edge in DRAIN with inflight=0. x_ready_out returns high in the following cycle.
- Reset (any time, mid-load or mid-stream):
  - y_valid_out=0, y_data_out=0, busy_out=0, shadow_full_out=0.
  - w_ready_out=1, x_ready_out=1.
  - FSM=LOAD, row_cnt=0, both banks zero, in-flight data discarded.

## Configuration
- SYSTOLIC_SAT_EN defined:
  - Product narrowing clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Every cell add saturates to the same range.
- SYSTOLIC_SAT_EN undefined: narrowing truncates and adds wrap, as above.

## Structure
- Package systolic_pkg holds:
  - default DATA_W and FRAC_W constants
  - weight-FSM state enum {LOAD, FULL, DRAIN}
  - fixed-point multiply and add functions, with saturation behaviour selected by SYSTOLIC_SAT_EN
- Sub-module sa_cell: one PE with active weight register, x forward register and psum register. It is instantiated ROWS×COLS times by generate loops.
- Skew/deskew shift registers, FSM and counters live in systolic_array.

## Test plan
- Load identity (diagonal 0x0100, rest 0), switch, then send x=[0x0100,0x0200,0x0300,0x0400] → 8 cycles later y=[0x0100,0x0200,0x0300,0x0400], one-cycle y_valid_out.
- Stream 10 distinct vectors back-to-back with all weights 0x0100 → 10 contiguous y_valid_out cycles, each lane = Σx, correct order.
- Switch requested while 3 vectors are in flight:
  - x_ready_out stays low until those 3 results emerge.
  - The 3 old results use the old weights.
  - The next vector uses the new weights.
- Overflow: all weights and x = 0x7F00:
  - without SYSTOLIC_SAT_EN → lane = wrapped truncation of Σ (bit-exact model)
  - with SYSTOLIC_SAT_EN → every lane 0x7FFF
- rst pulsed after 2 of 4 weight rows:
  - w_ready_out=1, shadow_full_out=0, y_valid_out=0.
  - switch_in ignored until 4 new rows are loaded.
  - Output is zeros before the first switch.
- switch_in held in LOAD, and switch_in coincident with the final row write → no swap. Swap happens only when switch_in is seen in FULL.
